// File: rtl/pixel_array_sequencer_if.sv
// rtl/pixel_array_sequencer_if.sv - control/strobe bundle between camera controller and pixel array sequencer
//
// Purpose: groups the frame handshake inputs and the pixel array strobe outputs.
// Ports (signals):
//   start, abort, continuous          controller -> sequencer, frame control
//   expose_cycles, convert_cycles     controller -> sequencer, phase lengths (CNT_W)
//   erase, expose, convert            sequencer -> array, phase strobes
//   read                              sequencer -> array, one-hot row select (ROWS)
//   busy, frame_done                  sequencer -> controller, status
// Modports: master = camera controller side, slave = sequencer side.
interface pixel_array_sequencer_if #(
    parameter int ROWS  = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic             continuous;
    logic [CNT_W-1:0] expose_cycles;
    logic [CNT_W-1:0] convert_cycles;
    logic             erase;
    logic             expose;
    logic             convert;
    logic [ROWS-1:0]  read;
    logic             busy;
    logic             frame_done;

    modport master (
        output start, abort, continuous, expose_cycles, convert_cycles,
        input  erase, expose, convert, read, busy, frame_done
    );

    modport slave (
        input  start, abort, continuous, expose_cycles, convert_cycles,
        output erase, expose, convert, read, busy, frame_done
    );
endinterface

// File: rtl/pixel_array_sequencer.sv
// rtl/pixel_array_sequencer.sv - frame sequencer driving erase/expose/convert/row-read strobes
//
// Purpose: runs IDLE -> ERASE -> EXPOSE -> CONVERT -> READ(row 0..ROWS-1) -> ERASE|IDLE,
// with per-frame latched expose/convert lengths, single-shot or continuous mode and
// synchronous abort.
// Ports:
//   clock   in  system clock, rising edge
//   reset   in  asynchronous, active-high
//   bus     slave modport of pixel_array_sequencer_if (start/abort/continuous,
//           expose_cycles/convert_cycles in; erase/expose/convert/read/busy/frame_done out)
// All outputs are registered and change on the same edge as the state.
module pixel_array_sequencer #(
    parameter int ROWS      = 4,
    parameter int CNT_W     = 8,
    parameter int ERASE_CYC = 5,
    parameter int READ_CYC  = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    pixel_array_sequencer_if.slave  bus
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYC - 1);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_CYC - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [ROW_W-1:0] row, row_n;
    logic [CNT_W-1:0] exp_len, exp_len_n;
    logic [CNT_W-1:0] conv_len, conv_len_n;
    logic             frame_done_n;

    // Terminal counts for the latched phases; a latched 0 behaves like 1.
    logic [CNT_W-1:0] exp_last;
    logic [CNT_W-1:0] conv_last;

    assign exp_last  = (exp_len  == '0) ? '0 : exp_len  - CNT_W'(1);
    assign conv_last = (conv_len == '0) ? '0 : conv_len - CNT_W'(1);

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        row_n        = row;
        exp_len_n    = exp_len;
        conv_len_n   = conv_len;
        frame_done_n = 1'b0;

        if (state != S_IDLE && bus.abort) begin
            // Abort drops everything without signalling frame completion.
            state_n = S_IDLE;
            cnt_n   = '0;
            row_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // abort outranks start even in IDLE.
                    if (bus.start && !bus.abort) begin
                        state_n    = S_ERASE;
                        cnt_n      = '0;
                        row_n      = '0;
                        exp_len_n  = bus.expose_cycles;
                        conv_len_n = bus.convert_cycles;
                    end
                end
                S_ERASE: begin
                    if (cnt == ERASE_LAST) begin
                        state_n = S_EXPOSE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                S_EXPOSE: begin
                    if (cnt == exp_last) begin
                        state_n = S_CONVERT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                S_CONVERT: begin
                    if (cnt == conv_last) begin
                        state_n = S_READ;
                        cnt_n   = '0;
                        row_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                S_READ: begin
                    if (cnt == READ_LAST) begin
                        cnt_n = '0;
                        if (row == ROW_LAST) begin
                            frame_done_n = 1'b1;
                            row_n        = '0;
                            // continuous is only looked at here, on the frame boundary;
                            // the next frame gets freshly latched lengths.
                            if (bus.continuous) begin
                                state_n    = S_ERASE;
                                exp_len_n  = bus.expose_cycles;
                                conv_len_n = bus.convert_cycles;
                            end else begin
                                state_n = S_IDLE;
                            end
                        end else begin
                            row_n = row + ROW_W'(1);
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    row_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            row      <= '0;
            exp_len  <= '0;
            conv_len <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            row      <= row_n;
            exp_len  <= exp_len_n;
            conv_len <= conv_len_n;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register
    // rather than lagging it by a cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.erase      <= 1'b0;
            bus.expose     <= 1'b0;
            bus.convert    <= 1'b0;
            bus.read       <= '0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.erase      <= (state_n == S_ERASE);
            bus.expose     <= (state_n == S_EXPOSE);
            bus.convert    <= (state_n == S_CONVERT);
            bus.read       <= (state_n == S_READ) ? (ROWS'(1) << row_n) : '0;
            bus.busy       <= (state_n != S_IDLE);
            bus.frame_done <= frame_done_n;
        end
    end
endmodule

// File: tb/tb_pixel_array_sequencer.sv
// tb/tb_pixel_array_sequencer.sv - self-checking bench for pixel_array_sequencer
module tb_pixel_array_sequencer;
    localparam int ROWS      = 4;
    localparam int CNT_W     = 8;
    localparam int ERASE_CYC = 5;
    localparam int READ_CYC  = 5;

    typedef struct packed {
        logic            erase;
        logic            expose;
        logic            convert;
        logic [ROWS-1:0] rd;
        logic            busy;
        logic            fd;
    } vec_t;

    localparam vec_t IDLE_V = '0;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;
    vec_t exp_q[$];
    bit   pend_fd;

    pixel_array_sequencer_if #(.ROWS(ROWS), .CNT_W(CNT_W)) bus ();

    pixel_array_sequencer #(
        .ROWS(ROWS), .CNT_W(CNT_W), .ERASE_CYC(ERASE_CYC), .READ_CYC(READ_CYC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t observed();
        vec_t o;
        o = {bus.erase, bus.expose, bus.convert, bus.read, bus.busy, bus.frame_done};
        return o;
    endfunction

    // Reference model: a frame is just a list of per-cycle output vectors.
    task automatic push_phase(input int n, input vec_t v);
        vec_t v2;
        for (int i = 0; i < n; i++) begin
            v2 = v;
            if (pend_fd) begin
                v2.fd   = 1'b1;
                pend_fd = 1'b0;
            end
            exp_q.push_back(v2);
        end
    endtask

    task automatic push_frame(input int e, input int c, input bit last);
        vec_t v;
        v = IDLE_V; v.busy = 1'b1; v.erase = 1'b1;
        push_phase(ERASE_CYC, v);
        v = IDLE_V; v.busy = 1'b1; v.expose = 1'b1;
        push_phase((e == 0) ? 1 : e, v);
        v = IDLE_V; v.busy = 1'b1; v.convert = 1'b1;
        push_phase((c == 0) ? 1 : c, v);
        for (int r = 0; r < ROWS; r++) begin
            v = IDLE_V; v.busy = 1'b1; v.rd = ROWS'(1) << r;
            push_phase(READ_CYC, v);
        end
        pend_fd = 1'b1;
        if (last) push_phase(1, IDLE_V);
    endtask

    task automatic step(input string tag);
        vec_t e;
        vec_t o;
        logic [3:0] act;
        @(posedge clock);
        #1;
        cyc++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
        o = observed();
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, o, e);
        end
        act = {o.erase, o.expose, o.convert, |o.rd};
        checks++;
        assert ($onehot0(act) && $onehot0(o.rd)) else begin
            failures++;
            $error("FAIL %s_onehot cyc=%0d observed=%b expected=onehot0", tag, cyc, o);
        end
    endtask

    task automatic run_frames(input string tag, input int hold_start, input int drop_cont_at,
                              input int chg_at, input int chg_val, output int busy_cnt);
        int i;
        i = 0;
        busy_cnt = 0;
        while (exp_q.size() > 0 && i < 3000) begin
            step(tag);
            if (bus.busy) busy_cnt++;
            i++;
            if (i >= hold_start) bus.start = 1'b0;
            if (i == drop_cont_at) bus.continuous = 1'b0;
            if (i == chg_at) bus.expose_cycles = CNT_W'(chg_val);
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL %s_timeout observed=%0d expected=0", tag, exp_q.size());
        end
    endtask

    task automatic idle_steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        int bc;
        int e;
        int c;
        int n;
        int flen;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        pend_fd  = 1'b0;
        reset    = 1'b1;
        bus.start          = 1'b0;
        bus.abort          = 1'b0;
        bus.continuous     = 1'b0;
        bus.expose_cycles  = '0;
        bus.convert_cycles = '0;

        #1;
        checks++;
        assert (observed() === IDLE_V) else begin
            failures++;
            $error("FAIL reset_state observed=%b expected=%b", observed(), IDLE_V);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        idle_steps("post_reset", 3);

        // 1: basic single frame
        bus.expose_cycles = 8'd10; bus.convert_cycles = 8'd20; bus.start = 1'b1;
        push_frame(10, 20, 1'b1);
        run_frames("t1", 1, -1, -1, 0, bc);
        checks++;
        assert (bc === 55) else begin
            failures++;
            $error("FAIL t1_busy_cycles observed=%0d expected=55", bc);
        end
        idle_steps("t1_idle", 3);

        // 2: zero lengths treated as one
        bus.expose_cycles = 8'd0; bus.convert_cycles = 8'd0; bus.start = 1'b1;
        push_frame(0, 0, 1'b1);
        run_frames("t2", 1, -1, -1, 0, bc);
        checks++;
        assert (bc === ERASE_CYC + 1 + 1 + ROWS * READ_CYC) else begin
            failures++;
            $error("FAIL t2_busy_cycles observed=%0d expected=%0d", bc, ERASE_CYC + 2 + ROWS * READ_CYC);
        end
        idle_steps("t2_idle", 2);

        // 3: continuous, expose changed mid-frame 1
        bus.expose_cycles = 8'd10; bus.convert_cycles = 8'd20; bus.continuous = 1'b1; bus.start = 1'b1;
        push_frame(10, 20, 1'b0);
        push_frame(3, 20, 1'b0);
        push_frame(3, 20, 1'b1);
        run_frames("t3", 1, 55 + 48 + 5, 5, 3, bc);
        checks++;
        assert (bc === 55 + 48 + 48) else begin
            failures++;
            $error("FAIL t3_busy_cycles observed=%0d expected=%0d", bc, 55 + 48 + 48);
        end
        idle_steps("t3_idle", 2);

        // 4: abort during row 2, then restart
        bus.expose_cycles = 8'd2; bus.convert_cycles = 8'd2; bus.start = 1'b1;
        push_frame(2, 2, 1'b1);
        step("t4");
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) step("t4");
        checks++;
        assert (bus.read === 4'b0100) else begin
            failures++;
            $error("FAIL t4_in_row2 observed=%b expected=0100", bus.read);
        end
        bus.abort = 1'b1;
        exp_q.delete();
        step("t4_abort");
        bus.abort = 1'b0;
        bus.start = 1'b1;
        push_frame(2, 2, 1'b1);
        run_frames("t4_restart", 1, -1, -1, 0, bc);
        idle_steps("t4_idle", 2);

        // 5: start held during frame ignored; start+abort in IDLE ignored
        bus.expose_cycles = 8'd4; bus.convert_cycles = 8'd3; bus.start = 1'b1;
        push_frame(4, 3, 1'b1);
        run_frames("t5", 25, -1, -1, 0, bc);
        bus.start = 1'b1; bus.abort = 1'b1;
        idle_steps("t5_start_abort", 3);
        bus.start = 1'b0; bus.abort = 1'b0;
        idle_steps("t5_idle", 2);

        // 6: async reset mid-expose
        bus.expose_cycles = 8'd10; bus.convert_cycles = 8'd5; bus.start = 1'b1;
        push_frame(10, 5, 1'b1);
        step("t6");
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) step("t6");
        #2 reset = 1'b1;
        #1;
        checks++;
        assert (observed() === IDLE_V) else begin
            failures++;
            $error("FAIL t6_async_reset observed=%b expected=%b", observed(), IDLE_V);
        end
        exp_q.delete();
        pend_fd = 1'b0;
        idle_steps("t6_in_reset", 2);
        reset = 1'b0;
        idle_steps("t6_after_reset", 10);

        // 7: randomized lengths and frame chains
        for (int k = 0; k < 6; k++) begin
            e = $urandom_range(0, 12);
            c = $urandom_range(0, 12);
            n = $urandom_range(1, 3);
            flen = ERASE_CYC + ((e == 0) ? 1 : e) + ((c == 0) ? 1 : c) + ROWS * READ_CYC;
            bus.expose_cycles  = CNT_W'(e);
            bus.convert_cycles = CNT_W'(c);
            bus.continuous     = (n > 1);
            bus.start          = 1'b1;
            for (int f = 0; f < n; f++) push_frame(e, c, f == n - 1);
            run_frames("t7_rand", 1, (n > 1) ? (n - 1) * flen + 2 : -1, -1, 0, bc);
            checks++;
            assert (bc === n * flen) else begin
                failures++;
                $error("FAIL t7_busy_cycles observed=%0d expected=%0d", bc, n * flen);
            end
            idle_steps("t7_idle", $urandom_range(1, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
